video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
// - Parametrised horizontal + vertical raster timing generator; successor to the fixed 455-count line timer.
// - Produces pixel/line counters, blank, sync, line and frame reset pulses.
// - Sits at the root of the video path; game objects, score and net logic decode hcnt/vcnt.
// PARAMETERS
// - HW            9    width of hcnt
// - VW            9    width of vcnt
// - H_TOTAL       455  clocks per line; hcnt runs 0..H_TOTAL-1
// - H_BLANK_END   80   hblank=1 for hcnt < H_BLANK_END
// - H_SYNC_START  32   hsync asserted for H_SYNC_START <= hcnt < H_SYNC_END
// - H_SYNC_END    64   must be <= H_BLANK_END
// - V_TOTAL       262  lines per frame; vcnt runs 0..V_TOTAL-1
// - V_BLANK_END   16   vblank=1 for vcnt < V_BLANK_END
// - V_SYNC_START  4    vsync asserted for V_SYNC_START <= vcnt < V_SYNC_END
// - V_SYNC_END    8    must be <= V_BLANK_END
// - SYNC_POL      1    1: syncs active-high; 0: hsync/vsync outputs inverted
// PORTS
// - clk          in   1   pixel clock; all state updates on posedge
// - reset        in   1   asynchronous, active-high
// - hcnt         out  HW  horizontal position
// - vcnt         out  VW  vertical position
// - hreset       out  1   1-cycle pulse while hcnt==0
// - vreset       out  1   1-cycle pulse while hcnt==0 && vcnt==0 (frame start)
// - hblank       out  1   horizontal blank
// - vblank       out  1   vertical blank
// - blank        out  1   hblank | vblank
// - hsync        out  1   horizontal sync, polarity per SYNC_POL
// - vsync        out  1   vertical sync, polarity per SYNC_POL
// BEHAVIOUR
// - Reset (async): hcnt=0, vcnt=0; hreset=vreset=0; hblank=vblank=blank=1; hsync,vsync inactive.
// - Counters: hcnt increments each advance; at H_TOTAL-1 it wraps to 0 and vcnt increments.
// - vcnt wraps V_TOTAL-1 -> 0 on the same edge hcnt wraps. No other wrap conditions; no saturation.
// - All outputs registered, computed from next-state counts: every decode is valid in the same cycle
//   as the hcnt/vcnt value it describes (zero latency relative to counters, no glitches).
// - hblank/vblank/hsync/vsync/hreset/vreset: pure functions of (hcnt,vcnt) per parameter table.
// - First advance after reset release: hcnt=1, vcnt=0; hreset/vreset not pulsed for the reset-held 0.
// - Next pulse of hreset at hcnt wrap (H_TOTAL clocks later); vreset every H_TOTAL*V_TOTAL clocks.
// - Reset mid-line/mid-frame: immediate return to reset values; no partial-line completion.
// - Parameter legality (elaboration check, $error): H_TOTAL<=2**HW, V_TOTAL<=2**VW,
//   H_SYNC_START<H_SYNC_END<=H_BLANK_END<H_TOTAL, same ordering vertically.
// CONFIGURATION
// - VTIM_CLKEN_EN defined: adds input pix_ce (1 bit, after reset in port list). Counters and all
//   registered outputs advance only on clk edges with pix_ce=1; with pix_ce=0 everything holds,
//   hreset/vreset included (a pulse lasts until the next enabled edge). Reset overrides pix_ce.
// - VTIM_CLKEN_EN undefined: no pix_ce port; advance on every clk edge.
// TESTING
// - Defaults, release reset, run 455 clk -> hcnt 0..454 then 0; hreset high exactly at second hcnt==0; vcnt=1.
// - Defaults, check line decodes -> hblank=1 for hcnt 0..79, 0 at 80..454; hsync=1 only for hcnt 32..63.
// - Defaults, run 455*262=119210 clk -> vcnt 261 wraps to 0 with hcnt; vreset single pulse; vblank for vcnt 0..15, vsync 4..7.
// - SYNC_POL=0, H_TOTAL=16, H_BLANK_END=6, H_SYNC 2..4 -> hsync=0 only at hcnt 2,3; hreset period 16.
// - Assert reset at hcnt=200,vcnt=100 -> same cycle (async) hcnt=vcnt=0, blank=1, syncs inactive.
// - VTIM_CLKEN_EN, pix_ce toggling 1/0 -> hcnt advances every 2nd clk; line period 910 clk; hreset 2 clk wide.

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hcnt/vcnt counters with registered blank, sync and
// line/frame-start decodes. Define VTIM_CLKEN_EN to add the pix_ce pixel clock-enable input.
module video_timing_gen #(
  parameter int HW           = 9,
  parameter int VW           = 9,
  parameter int H_TOTAL      = 455,
  parameter int H_BLANK_END  = 80,
  parameter int H_SYNC_START = 32,
  parameter int H_SYNC_END   = 64,
  parameter int V_TOTAL      = 262,
  parameter int V_BLANK_END  = 16,
  parameter int V_SYNC_START = 4,
  parameter int V_SYNC_END   = 8,
  parameter int SYNC_POL     = 1
) (
  input  logic          clk,
  input  logic          reset,
`ifdef VTIM_CLKEN_EN
  input  logic          pix_ce,
`endif
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hreset,
  output logic          vreset,
  output logic          hblank,
  output logic          vblank,
  output logic          blank,
  output logic          hsync,
  output logic          vsync
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_BE   = HW'(H_BLANK_END);
  localparam logic [HW-1:0] H_SS   = HW'(H_SYNC_START);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC_END);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_BE   = VW'(V_BLANK_END);
  localparam logic [VW-1:0] V_SS   = VW'(V_SYNC_START);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC_END);
  // Wire level of hsync/vsync while the sync interval is not active.
  localparam logic SYNC_IDLE = (SYNC_POL == 0);

  if (!(H_TOTAL <= 2**HW && V_TOTAL <= 2**VW)) begin : g_bad_width
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in HW/VW");
  end
  if (!(H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_BLANK_END && H_BLANK_END < H_TOTAL))
  begin : g_bad_h
    $error("video_timing_gen: horizontal timing must satisfy SYNC_START<SYNC_END<=BLANK_END<TOTAL");
  end
  if (!(V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_BLANK_END && V_BLANK_END < V_TOTAL))
  begin : g_bad_v
    $error("video_timing_gen: vertical timing must satisfy SYNC_START<SYNC_END<=BLANK_END<TOTAL");
  end

  logic advance;
`ifdef VTIM_CLKEN_EN
  assign advance = pix_ce;
`else
  assign advance = 1'b1;
`endif

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic hreset_q, hreset_d, vreset_q, vreset_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d, blank_q, blank_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;

  always_comb begin
    // NOTE: every _d starts as its _q, so a disabled edge holds all state and no latch is inferred.
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    hreset_d = hreset_q;
    vreset_d = vreset_q;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    blank_d  = blank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (advance) begin
      // NOTE: blocking assignments here let the decodes below read the freshly computed next counts.
      hcnt_d = (hcnt_q == H_LAST) ? '0 : hcnt_q + HW'(1);
      if (hcnt_q == H_LAST) begin
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end
      // Decoding next-state counts keeps every flag aligned with the count it describes.
      hreset_d = (hcnt_d == '0);
      vreset_d = (hcnt_d == '0) && (vcnt_d == '0);
      hblank_d = (hcnt_d < H_BE);
      vblank_d = (vcnt_d < V_BE);
      blank_d  = hblank_d | vblank_d;
      hsync_d  = ((hcnt_d >= H_SS) && (hcnt_d < H_SE)) ? ~SYNC_IDLE : SYNC_IDLE;
      vsync_d  = ((vcnt_d >= V_SS) && (vcnt_d < V_SE)) ? ~SYNC_IDLE : SYNC_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset forces blanking with syncs idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hreset_q <= 1'b0;
      vreset_q <= 1'b0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      blank_q  <= 1'b1;
      hsync_q  <= SYNC_IDLE;
      vsync_q  <= SYNC_IDLE;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      hreset_q <= hreset_d;
      vreset_q <= vreset_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      blank_q  <= blank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign hreset = hreset_q;
  assign vreset = vreset_q;
  assign hblank = hblank_q;
  assign vblank = vblank_q;
  assign blank  = blank_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-parameter instance and a small SYNC_POL=0 instance, both
// checked every clock against an advance-count model, plus a vector table and corner sequences.
module tb_video_timing_gen;

  typedef struct {
    int ht, hbe, hss, hse, vt, vbe, vss, vse, pol;
  } tp_t;

  typedef struct {
    int n;
    int h;
    int v;
    bit hr, vr, hb, vb, hs, vs;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic [8:0] hcnt_def;
  logic [8:0] vcnt_def;
  logic hreset_def, vreset_def, hblank_def, vblank_def, blank_def, hsync_def, vsync_def;
  logic [3:0] hcnt_sml;
  logic [2:0] vcnt_sml;
  logic hreset_sml, vreset_sml, hblank_sml, vblank_sml, blank_sml, hsync_sml, vsync_sml;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_adv = 0;
  bit  ce_rand = 1'b0;
  bit  ce_toggle = 1'b0;
  tp_t p_def, p_sml;
  vec_t vecs[$];

  always #5 clk = ~clk;

  video_timing_gen u_def (
    .clk(clk), .reset(reset),
`ifdef VTIM_CLKEN_EN
    .pix_ce(ce),
`endif
    .hcnt(hcnt_def), .vcnt(vcnt_def), .hreset(hreset_def), .vreset(vreset_def),
    .hblank(hblank_def), .vblank(vblank_def), .blank(blank_def),
    .hsync(hsync_def), .vsync(vsync_def)
  );

  video_timing_gen #(
    .HW(4), .VW(3), .H_TOTAL(16), .H_BLANK_END(6), .H_SYNC_START(2), .H_SYNC_END(4),
    .V_TOTAL(5), .V_BLANK_END(3), .V_SYNC_START(1), .V_SYNC_END(2), .SYNC_POL(0)
  ) u_sml (
    .clk(clk), .reset(reset),
`ifdef VTIM_CLKEN_EN
    .pix_ce(ce),
`endif
    .hcnt(hcnt_sml), .vcnt(vcnt_sml), .hreset(hreset_sml), .vreset(vreset_sml),
    .hblank(hblank_sml), .vblank(vblank_sml), .blank(blank_sml),
    .hsync(hsync_sml), .vsync(vsync_sml)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int h, input int v, input logic hr, input logic vr,
                                       input logic hb, input logic vb, input logic bl,
                                       input logic hs, input logic vs);
    return {h[11:0], v[11:0], hr, vr, hb, vb, bl, hs, vs, 1'b0};
  endfunction

  // Outputs after n enabled edges since reset release, straight from the raster definition.
  function automatic logic [31:0] model(input int n, input tp_t p);
    int h, v;
    bit up, hact, vact, hb, vb;
    h    = n % p.ht;
    v    = (n / p.ht) % p.vt;
    up   = (n > 0);
    hact = up && (h >= p.hss) && (h < p.hse);
    vact = up && (v >= p.vss) && (v < p.vse);
    hb   = (h < p.hbe);
    vb   = (v < p.vbe);
    return pack(h, v, up && h == 0, up && h == 0 && v == 0, hb, vb, hb | vb,
                (p.pol != 0) ? hact : !hact, (p.pol != 0) ? vact : !vact);
  endfunction

  function automatic logic [31:0] act_def();
    return pack(int'(hcnt_def), int'(vcnt_def), hreset_def, vreset_def, hblank_def, vblank_def,
                blank_def, hsync_def, vsync_def);
  endfunction

  function automatic logic [31:0] act_sml();
    return pack(int'(hcnt_sml), int'(vcnt_sml), hreset_sml, vreset_sml, hblank_sml, vblank_sml,
                blank_sml, hsync_sml, vsync_sml);
  endfunction

  function automatic logic get_sig(input int which);
    case (which)
      0:       return hreset_sml;
      1:       return vreset_sml;
      default: return hreset_def;
    endcase
  endfunction

  // One clock: drive ce, take the edge, then compare both instances 1 time unit later.
  task automatic step();
`ifdef VTIM_CLKEN_EN
    if (ce_toggle) ce = ~ce;
    else if (ce_rand) ce = 1'($urandom_range(0, 1));
`endif
    @(posedge clk);
    if (!reset && ce) n_adv++;
    #1;
    check("def_model", act_def(), model(n_adv, p_def));
    check("sml_model", act_sml(), model(n_adv, p_sml));
  endtask

  // Clocks from one rising edge of the chosen pulse to the next.
  task automatic measure_period(input string name, input int which, input int bound, input int expv);
    int k, cnt;
    k = 0;
    while (!get_sig(which) && k < bound) begin step(); k++; end
    cnt = 0;
    while (get_sig(which) && cnt < bound) begin step(); cnt++; end
    while (!get_sig(which) && cnt < bound) begin step(); cnt++; end
    if (k >= bound) cnt = bound + 1;
    check(name, cnt, expv);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    check("async_hcnt", act_def() & 32'hFFFF_FF00, 32'h0);
    check("async_flags", {hreset_def, vreset_def, hblank_def, vblank_def, blank_def, hsync_def, vsync_def},
          7'b0011100);
    check("async_sml", {hcnt_sml, vcnt_sml, blank_sml, hsync_sml, vsync_sml}, 10'b0000000111);
    n_adv = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int mask, len;
    p_def = '{455, 80, 32, 64, 262, 16, 4, 8, 1};
    p_sml = '{16, 6, 2, 4, 5, 3, 1, 2, 0};
    vecs.push_back('{1, 1, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{31, 31, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{32, 32, 0, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{63, 63, 0, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{64, 64, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{79, 79, 0, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{80, 80, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{454, 454, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{455, 0, 1, 1, 0, 1, 1, 0, 0});
    vecs.push_back('{456, 1, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{1820, 0, 4, 1, 0, 1, 1, 0, 1});
    vecs.push_back('{3639, 454, 7, 0, 0, 0, 1, 0, 1});
    vecs.push_back('{3640, 0, 8, 1, 0, 1, 1, 0, 0});
    vecs.push_back('{7279, 454, 15, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{7280, 0, 16, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{7360, 80, 16, 0, 0, 0, 0, 0, 0});

    reset = 1'b1;
    ce    = 1'b1;
    #12;
    check("rst_def", act_def(), pack(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    check("rst_sml", act_sml(), pack(0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    step();
    step();
    reset = 1'b0;

    // Vector table on the default instance.
    foreach (vecs[i]) begin
      while (n_adv < vecs[i].n) step();
      check($sformatf("tbl%0d_hcnt", i), hcnt_def, vecs[i].h);
      check($sformatf("tbl%0d_vcnt", i), vcnt_def, vecs[i].v);
      check($sformatf("tbl%0d_flags", i),
            {hreset_def, vreset_def, hblank_def, vblank_def, blank_def, hsync_def, vsync_def},
            {vecs[i].hr, vecs[i].vr, vecs[i].hb, vecs[i].vb, vecs[i].hb | vecs[i].vb,
             vecs[i].hs, vecs[i].vs});
    end

    // Mid-frame asynchronous reset at hcnt=200, vcnt=100.
    while (n_adv < 100 * 455 + 200) step();
    check("mid_pos", {hcnt_def, vcnt_def}, {9'd200, 9'd100});
    async_reset();

    // Small instance: hsync low only at hcnt 2,3; line and frame periods.
    len = 0;
    while (hcnt_sml != 4'd15 && len < 40) begin step(); len++; end
    mask = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (!hsync_sml) mask |= (1 << hcnt_sml);
    end
    check("sml_hsync_mask", mask, 32'h0000_000C);
    measure_period("sml_hreset_period", 0, 40, 16);
    measure_period("sml_vreset_period", 1, 200, 80);

`ifdef VTIM_CLKEN_EN
    // Clock enable toggling 1/0: pixel advance every second clock.
    ce_toggle = 1'b1;
    measure_period("ce_line_period", 2, 2000, 910);
    len = 0;
    while (!hreset_def && len < 2000) begin step(); len++; end
    len = 0;
    while (hreset_def && len < 10) begin step(); len++; end
    check("ce_hreset_width", len, 2);
    ce_toggle = 1'b0;
    ce_rand   = 1'b1;
`endif

    // Randomised run lengths, clock enables and reset pulses.
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, 500);
      for (int c = 0; c < len; c++) step();
      if ($urandom_range(0, 2) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
